// File: rtl/state_dump_unit.sv
// State dump unit: free-running performance counters plus a 43-item dump
// stream (counter snapshot, register file, data memory) behind valid/ready.
module state_dump_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        dump_req_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [4:0]  mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [5:0]  out_tag_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [5:0] REG_BASE  = 6'd3;
  localparam logic [5:0] MEM_BASE  = 6'd35;
  localparam logic [5:0] LAST_IDX  = 6'd42;
  localparam logic [5:0] NUM_ITEMS = 6'd43;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;
  logic [31:0] snap_cycle_q, snap_stall_q, snap_flush_q;
  logic        valid_q, last_q;
  logic [31:0] data_q;
  logic [5:0]  tag_q;

  logic        snap_en, load, finish;
  logic [31:0] item_data;
  logic [5:0]  item_tag;
  logic        item_last;
  logic [5:0]  reg_off, mem_off;

  // Counters run regardless of dump activity.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot create races.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (start_i) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (stall_i) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  // Item selection and read addresses are a pure function of idx.
  always_comb begin
    item_data  = '0;
    item_tag   = '0;
    item_last  = 1'b0;
    reg_addr_o = '0;
    mem_addr_o = '0;
    reg_off    = idx_q - REG_BASE;
    mem_off    = idx_q - MEM_BASE;
    if (idx_q < REG_BASE) begin
      item_tag = idx_q;
      case (idx_q[1:0])
        2'd0:    item_data = snap_cycle_q;
        2'd1:    item_data = snap_stall_q;
        default: item_data = snap_flush_q;
      endcase
    end else if (idx_q < MEM_BASE) begin
      reg_addr_o = reg_off[4:0];
      item_tag   = {1'b1, reg_off[4:0]};
      item_data  = reg_data_i;
    end else if (idx_q <= LAST_IDX) begin
      mem_addr_o = {mem_off[2:0], 2'b00};
      item_tag   = {3'b001, mem_off[2:0]};
      item_data  = mem_data_i;
      item_last  = (idx_q == LAST_IDX);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_en = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_req_i) begin
          snap_en = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // An empty output slot only exists on the first RUN cycle.
        if (idx_q < NUM_ITEMS) begin
          if (!valid_q || out_ready_i) begin
            load  = 1'b1;
            idx_d = idx_q + 6'd1;
          end
        end else if (valid_q && out_ready_i) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_cycle_q <= '0;
      snap_stall_q <= '0;
      snap_flush_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (snap_en) begin
        snap_cycle_q <= cycle_cnt_q;
        snap_stall_q <= stall_cnt_q;
        snap_flush_q <= flush_cnt_q;
      end
    end
  end

  // Output slot holds its contents until the sink accepts them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= item_data;
      tag_q   <= item_tag;
      last_q  <= item_last;
    end else if (finish) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_tag_o   = tag_q;
  assign out_last_o  = last_q;
  assign busy_o      = (state_q == RUN);
  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// Self-checking bench for state_dump_unit: queue-based dump model, per-cycle
// compare, randomized traffic and directed corner cases.
module tb_state_dump_unit;

  logic        clk_i;
  logic        rst_i;
  logic        start_i, stall_i, flush_i, dump_req_i, out_ready_i;
  logic [4:0]  reg_addr_o, mem_addr_o;
  logic [31:0] reg_data_i, mem_data_i;
  logic        out_valid_o, out_last_o, busy_o;
  logic [31:0] out_data_o;
  logic [5:0]  out_tag_o;
  logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

  logic [31:0] regs [32];
  logic [7:0]  mem  [32];

  assign reg_data_i = regs[reg_addr_o];
  assign mem_data_i = {mem[mem_addr_o + 5'd3], mem[mem_addr_o + 5'd2],
                       mem[mem_addr_o + 5'd1], mem[mem_addr_o]};

  state_dump_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .flush_i(flush_i), .dump_req_i(dump_req_i), .reg_addr_o(reg_addr_o),
    .reg_data_i(reg_data_i), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_tag_o(out_tag_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  tag;
    logic        last;
  } item_t;

  // Reference model: counters plus a queue of the items a dump must produce.
  item_t       m_q[$];
  logic        m_busy = 1'b0;
  logic        m_first = 1'b0;
  logic [31:0] m_cycle = '0, m_stall = '0, m_flush = '0;
  logic        stall_preload = 1'b0;
  logic        cnt_chk_en = 1'b1;

  int checks = 0;
  int errors = 0;
  int acc_total = 0, last_total = 0, tag32_cycles = 0;
  logic [31:0] tag0_data, tag8_data, tag33_data;
  logic [5:0]  last_tag;

  function automatic item_t make_item(input int i);
    item_t it;
    int a;
    it.last = (i == 42);
    if (i < 3) begin
      it.tag  = 6'(i);
      it.data = (i == 0) ? m_cycle : (i == 1) ? m_stall : m_flush;
    end else if (i < 35) begin
      it.tag  = 6'(32 + i - 3);
      it.data = regs[i - 3];
    end else begin
      a       = 4 * (i - 35);
      it.tag  = 6'(8 + i - 35);
      it.data = {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    end
    return it;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_q.delete();
      m_busy  <= 1'b0;
      m_first <= 1'b0;
      m_cycle <= '0;
      m_stall <= '0;
      m_flush <= '0;
    end else begin
      if (m_busy) begin
        if (m_first) m_first <= 1'b0;
        else if (out_ready_i) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_busy <= 1'b0;
        end
      end else if (dump_req_i) begin
        for (int i = 0; i < 43; i++) m_q.push_back(make_item(i));
        m_busy  <= 1'b1;
        m_first <= 1'b1;
      end
      if (start_i) m_cycle <= m_cycle + 32'd1;
      if (stall_preload) m_stall <= 32'hFFFF_FFFF;
      else if (start_i && stall_i) m_stall <= m_stall + 32'd1;
      if (start_i && flush_i) m_flush <= m_flush + 32'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic exp_valid;
    int   idx, exp_reg, exp_mem;
    exp_valid = m_busy && !m_first;
    check("busy", 32'(busy_o), 32'(m_busy));
    check("valid", 32'(out_valid_o), 32'(exp_valid));
    if (cnt_chk_en) begin
      check("cycle_cnt", cycle_cnt_o, m_cycle);
      check("stall_cnt", stall_cnt_o, m_stall);
      check("flush_cnt", flush_cnt_o, m_flush);
    end
    idx     = m_busy ? (43 - m_q.size() + (exp_valid ? 1 : 0)) : 0;
    exp_reg = (idx >= 3 && idx <= 34) ? idx - 3 : 0;
    exp_mem = (idx >= 35 && idx <= 42) ? 4 * (idx - 35) : 0;
    check("reg_addr", 32'(reg_addr_o), 32'(exp_reg));
    check("mem_addr", 32'(mem_addr_o), 32'(exp_mem));
    if (exp_valid && m_q.size() > 0) begin
      check("item_data", out_data_o, m_q[0].data);
      check("item_tag", 32'(out_tag_o), 32'(m_q[0].tag));
      check("item_last", 32'(out_last_o), 32'(m_q[0].last));
    end else begin
      check("idle_last", 32'(out_last_o), 32'd0);
    end
    if (out_valid_o && out_ready_i) begin
      acc_total++;
      if (out_tag_o == 6'd0)  tag0_data  = out_data_o;
      if (out_tag_o == 6'd8)  tag8_data  = out_data_o;
      if (out_tag_o == 6'd33) tag33_data = out_data_o;
      if (out_last_o) begin
        last_total++;
        last_tag = out_tag_o;
      end
    end
    if (out_valid_o && out_tag_o == 6'd32) tag32_cycles++;
  endtask

  task automatic step();
    @(negedge clk_i);
    compare_cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drain();
    int k = 0;
    dump_req_i  = 1'b0;
    out_ready_i = 1'b1;
    while (m_busy && k < 200) begin
      step();
      k++;
    end
    check("drain_timeout", 32'(m_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, held, acc0, last0, t32_0, k;
    rst_i = 1'b0;
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    dump_req_i = 1'b0; out_ready_i = 1'b1;
    for (int r = 0; r < 32; r++) regs[r] = 32'(r * 3);
    for (int b = 0; b < 32; b++) mem[b] = 8'($urandom);
    mem[0] = 8'd5; mem[1] = 8'd0; mem[2] = 8'd0; mem[3] = 8'd0;
    repeat (3) step();
    rst_i = 1'b1;
    step();
    check("rst_cycle", cycle_cnt_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);

    // Counting: stall on 3 edges, flush on 2, one edge with both.
    for (int i = 0; i < 10; i++) begin
      start_i = 1'b1;
      stall_i = (i == 0 || i == 3 || i == 5);
      flush_i = (i == 3 || i == 7);
      step();
    end
    start_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
    repeat (5) step();
    stall_i = 1'b0; flush_i = 1'b0;
    check("count_cycle", cycle_cnt_o, 32'd10);
    check("count_stall", stall_cnt_o, 32'd3);
    check("count_flush", flush_cnt_o, 32'd2);

    // Snapshot at cycle 100 with a full-rate dump.
    start_i = 1'b1;
    k = 0;
    while (m_cycle != 32'd100 && k < 200) begin
      stall_i = 1'($urandom % 2);
      flush_i = 1'($urandom % 2);
      step();
      k++;
    end
    stall_i = 1'b0; flush_i = 1'b0;
    check("pre_dump_cycle", cycle_cnt_o, 32'd100);
    acc0 = acc_total; last0 = last_total;
    dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    check("dump_busy", 32'(busy_o), 32'd1);
    check("dump_no_valid_yet", 32'(out_valid_o), 32'd0);
    step();
    check("first_tag", 32'(out_tag_o), 32'd0);
    check("first_data", out_data_o, 32'd100);
    check("cycle_advanced", cycle_cnt_o, 32'd102);
    n = 0;
    while (out_valid_o && n < 100) begin
      n++;
      dump_req_i = (n == 10);
      step();
    end
    dump_req_i = 1'b0;
    check("valid_run_len", 32'(n), 32'd43);
    check("busy_after_dump", 32'(busy_o), 32'd0);
    check("accepted_full", 32'(acc_total - acc0), 32'd43);
    check("tag33_data", tag33_data, 32'd3);
    check("tag8_data", tag8_data, 32'd5);
    check("last_count", 32'(last_total - last0), 32'd1);
    check("last_tag", 32'(last_tag), 32'd15);
    step();
    check("mid_req_ignored", 32'(busy_o), 32'd0);

    // Backpressure on the tag 32 item.
    acc0 = acc_total; t32_0 = tag32_cycles; held = 0;
    dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    k = 0;
    while (busy_o && k < 200) begin
      out_ready_i = !(out_valid_o && out_tag_o == 6'd32 && held < 4);
      if (!out_ready_i) held++;
      step();
      k++;
    end
    out_ready_i = 1'b1;
    check("bp_tag32_cycles", 32'(tag32_cycles - t32_0), 32'd5);
    check("bp_accepted", 32'(acc_total - acc0), 32'd43);

    // Randomized traffic; arrays only change while no dump is active.
    for (int c = 0; c < 700; c++) begin
      if (!m_busy && ($urandom % 4 == 0)) begin
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        for (int b = 0; b < 32; b++) mem[b] = 8'($urandom);
      end
      start_i     = ($urandom % 4) != 0;
      stall_i     = 1'($urandom % 2);
      flush_i     = 1'($urandom % 2);
      out_ready_i = ($urandom % 3) != 0;
      dump_req_i  = ($urandom % 8) == 0;
      step();
    end
    drain();

    // Reset in the middle of a dump.
    start_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    acc0 = acc_total;
    dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    k = 0;
    while (acc_total - acc0 < 20 && k < 100) begin
      step();
      k++;
    end
    check("pre_reset_items", 32'(acc_total - acc0), 32'd20);
    rst_i = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_valid", 32'(out_valid_o), 32'd0);
    check("arst_data", out_data_o, 32'd0);
    check("arst_tag", 32'(out_tag_o), 32'd0);
    check("arst_last", 32'(out_last_o), 32'd0);
    check("arst_cycle", cycle_cnt_o, 32'd0);
    check("arst_stall", stall_cnt_o, 32'd0);
    check("arst_flush", flush_cnt_o, 32'd0);
    check("arst_reg_addr", 32'(reg_addr_o), 32'd0);
    check("arst_mem_addr", 32'(mem_addr_o), 32'd0);
    step();
    rst_i = 1'b1;
    step();
    dump_req_i = 1'b1;
    step();
    dump_req_i = 1'b0;
    step();
    check("restart_valid", 32'(out_valid_o), 32'd1);
    check("restart_tag", 32'(out_tag_o), 32'd0);
    drain();

    // Stall counter wrap from a preloaded all-ones value.
    start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    cnt_chk_en = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    stall_preload = 1'b1;
    step();
    release dut.stall_cnt_q;
    stall_preload = 1'b0;
    check("preload_stall", stall_cnt_o, 32'hFFFF_FFFF);
    start_i = 1'b1; stall_i = 1'b1;
    step();
    start_i = 1'b0; stall_i = 1'b0;
    check("stall_wrap", stall_cnt_o, 32'd0);
    cnt_chk_en = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset: clk_i (rising edge) and rst_i (asynchronous, active-low).
REQ-002 Ports SHALL be exactly as follows:
- clk_i  in  1  clock
- rst_i  in  1  async active-low reset
- start_i  in  1  counting enable
- stall_i  in  1  one pipeline stall this cycle
- flush_i  in  1  one pipeline flush this cycle
- dump_req_i  in  1  request a state dump
- reg_addr_o  out  5  register-file read address
- reg_data_i  in  32  register-file read data, combinational from reg_addr_o
- mem_addr_o  out  5  data-memory byte address, word aligned
- mem_data_i  in  32  data-memory word, little-endian {m[a+3],m[a+2],m[a+1],m[a]}, combinational
- out_valid_o  out  1  dump item valid
- out_ready_i  in  1  sink accepts item
- out_data_o  out  32  item value
- out_tag_o  out  6  item identity
- out_last_o  out  1  final item of dump
- busy_o  out  1  dump in progress
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  32 each  live counters

Function
REQ-003 cycle_cnt_o SHALL increment by 1 at every rising edge where start_i=1, wrapping from 0xFFFFFFFF to 0.
REQ-004 stall_cnt_o and flush_cnt_o SHALL increment at every rising edge where start_i=1 and stall_i=1 or flush_i=1 respectively; both SHALL increment in the same cycle if both inputs are high; each SHALL wrap at 2^32.
REQ-005 Counters SHALL keep counting during a dump.
REQ-006 FSM states SHALL be IDLE and RUN; busy_o=1 exactly when the state is RUN.
REQ-007 In IDLE, dump_req_i=1 at an edge SHALL snapshot all three counters (pre-increment values at that edge), clear item index idx to 0, and enter RUN.
REQ-008 dump_req_i SHALL be ignored while in RUN.
REQ-009 Each dump SHALL emit 43 items in this order:
- idx 0-2: snapshot cycle/stall/flush, tags 0, 1, 2
- idx 3-34: register r = idx-3, tag 32+r
- idx 35-42: memory word w = idx-35 at byte address 4w, tag 8+w
REQ-010 reg_addr_o SHALL equal idx-3 during the register phase and 0 otherwise; mem_addr_o SHALL equal 4*(idx-35) during the memory phase and 0 otherwise.
REQ-011 Item load:
- At the edge after entry to RUN, and at every edge where out_valid_o=1 and out_ready_i=1 with items remaining, the block SHALL register the item for the current idx into out_data_o/out_tag_o, assert out_valid_o, and increment idx.
- First item valid latency: 1 cycle after the request edge.
- Back-to-back acceptance: one item per cycle; 43 items in 43 cycles.
REQ-012 While out_valid_o=1 and out_ready_i=0, out_data_o, out_tag_o and out_last_o SHALL hold stable.
REQ-013 out_last_o SHALL be 1 only with tag 15 (memory word 7).
REQ-014 When the last item is accepted, the block SHALL at that edge clear out_valid_o and out_last_o and return to IDLE.
REQ-015 A dump_req_i at the same edge that returns the block to IDLE SHALL be ignored; a new request is accepted from the next edge.
REQ-016 out_valid_o SHALL never rise in IDLE.

Reset
REQ-017 rst_i=0 SHALL immediately force:
- all counters, snapshots, idx and outputs to 0
- state to IDLE
REQ-018 Reset during RUN SHALL abort the dump with no further items emitted; the next dump SHALL restart at idx 0.

Verification
REQ-019 Count: start_i=1 for 10 edges with stall_i high on 3 of them and flush_i high on 2 of them, one edge having both -> cycle=10, stall=3, flush=2; with start_i=0, all three counters frozen.
REQ-020 Full dump, out_ready_i=1: register r holds r*3 and memory word 0 = 5 -> 43 consecutive valid cycles; tag 33 data=3; tag 8 data=5; out_last_o=1 only on tag 15; busy_o drops after the last item.
REQ-021 Backpressure: out_ready_i=0 for 4 cycles on the tag 32 item -> data and tag held for 4 cycles; no item lost or duplicated; total 43 items.
REQ-022 Snapshot: dump requested when cycle_cnt_o=100 -> item 0 data=100 while cycle_cnt_o keeps advancing; a second dump_req_i pulse mid-dump is ignored.
REQ-023 Reset mid-dump after 20 items -> all outputs 0 asynchronously; a new request yields tag 0 first.
REQ-024 Wrap: stall_cnt preloaded to 0xFFFFFFFF, then start_i=1 and stall_i=1 for one edge -> stall_cnt=0.
